frame_collector: RTL

Input-side stage that collects a serial stream of nine signed fixed-point samples into one parallel frame and hands it to the mean/variance normalisation stage. It sits directly upstream of the normalisation and neuron layers. It checks frame delimiting on the input stream and holds each completed frame until the downstream stage accepts it.

---
 rtl/frame_collector_if.sv | 36 +++
 rtl/frame_collector.sv | 110 +++++++++++
 2 files changed

// File: rtl/frame_collector_if.sv
// Sample-in / frame-out bundle for frame_collector.
// out_sum exists only when FRAME_SUM_EN is defined.
interface frame_collector_if #(
  parameter int DATA_W = 16,
  parameter int N      = 9
);
  logic [DATA_W-1:0]        in_data;
  logic                     in_valid;
  logic                     in_last;
  logic                     in_ready;
  logic [N*DATA_W-1:0]      out_frame;
  logic                     out_valid;
  logic                     out_ready;
  logic                     frame_err;
  logic [7:0]               frame_cnt;
`ifdef FRAME_SUM_EN
  logic signed [DATA_W+3:0] out_sum;
`endif

  // master: sample source plus downstream consumer; slave: the collector
  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_frame, out_valid, frame_err, frame_cnt
`ifdef FRAME_SUM_EN
    , input out_sum
`endif
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_frame, out_valid, frame_err, frame_cnt
`ifdef FRAME_SUM_EN
    , output out_sum
`endif
  );
endinterface

// File: rtl/frame_collector.sv
// Collects N serial signed samples into one parallel frame, checks in_last delimiting.
// Optional FRAME_SUM_EN adds a registered signed frame sum (out_sum).
//
// state      | meaning
// FILL       | accepting samples into slots 0..N-1
// HOLD       | frame complete, waiting for out_ready, input stalled
// HOLD_DRAIN | frame complete but too long; discarding input until in_last
// DRAIN      | frame already taken; still discarding input until in_last
module frame_collector #(
  parameter int DATA_W = 16,
  parameter int N      = 9
) (
  input logic          clk,
  input logic          rst,
  frame_collector_if.slave bus
);
  typedef enum logic [1:0] {FILL, HOLD, HOLD_DRAIN, DRAIN} state_t;

  localparam logic [3:0] LAST_SLOT = 4'(N - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       accept;

  assign accept = bus.in_valid && bus.in_ready;

`ifdef FRAME_SUM_EN
  logic signed [DATA_W+3:0] acc;
  logic signed [DATA_W+3:0] sample_ext;
  assign sample_ext = {{4{bus.in_data[DATA_W-1]}}, bus.in_data};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= FILL;
      cnt           <= '0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_frame <= '0;
      bus.frame_err <= 1'b0;
      bus.frame_cnt <= '0;
`ifdef FRAME_SUM_EN
      acc           <= '0;
      bus.out_sum   <= '0;
`endif
    end else begin
      bus.frame_err <= 1'b0;
      case (state)
        FILL: begin
          bus.in_ready <= 1'b1;
          if (accept) begin
            if (cnt != LAST_SLOT) begin
              if (bus.in_last) begin
                cnt           <= '0;
                bus.frame_err <= 1'b1;
`ifdef FRAME_SUM_EN
                acc           <= '0;
`endif
              end else begin
                bus.out_frame[int'(cnt)*DATA_W +: DATA_W] <= bus.in_data;
                cnt <= cnt + 4'd1;
`ifdef FRAME_SUM_EN
                acc <= acc + sample_ext;
`endif
              end
            end else begin
              bus.out_frame[int'(cnt)*DATA_W +: DATA_W] <= bus.in_data;
              cnt           <= '0;
              bus.out_valid <= 1'b1;
`ifdef FRAME_SUM_EN
              acc           <= '0;
              bus.out_sum   <= acc + sample_ext;
`endif
              if (bus.in_last) begin
                state        <= HOLD;
                bus.in_ready <= 1'b0;
              end else begin
                state         <= HOLD_DRAIN;
                bus.frame_err <= 1'b1;
              end
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.frame_cnt <= bus.frame_cnt + 8'd1;
            bus.in_ready  <= 1'b1;
            state         <= FILL;
          end
        end
        HOLD_DRAIN: begin
          // drain finishing first degenerates into a plain HOLD
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.frame_cnt <= bus.frame_cnt + 8'd1;
            state         <= (accept && bus.in_last) ? FILL : DRAIN;
          end else if (accept && bus.in_last) begin
            bus.in_ready <= 1'b0;
            state        <= HOLD;
          end
        end
        DRAIN: begin
          if (accept && bus.in_last) state <= FILL;
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule
